eth_tx_fcs_ctrl: RTL and testbench

Ethernet TX frame sequencer that sits between the MAC frame source and the GMII/RGMII byte transmitter. It streams frame bytes through, feeds every byte to a CRC32_D8 instance, and zero-pads short frames to MIN_LEN bytes when PAD_EN=1. It then appends the 4-byte FCS. It owns the CRC register (init, update, hold, shift-out) and the byte-level handshakes on both sides.

---
 rtl/eth_tx_fcs_ctrl.sv | 174 +++++++++++++++++
 tb/tb_eth_tx_fcs_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_fcs_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_tx_fcs_ctrl: Ethernet TX byte sequencer. Passes frame bytes through,    |
// | zero-pads short frames and appends the CRC-32 FCS.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module eth_tx_fcs_ctrl #(
  parameter int PAD_EN  = 1,
  parameter int MIN_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        frame_done,
  output logic [31:0] fcs_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_FCS  = 2'd3;

  localparam logic [8:0]  MIN_LEN_W = 9'(MIN_LEN);
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

  // Serial CRC-32 (poly 0x04C11DB7) with data bits fed LSB first.
  function automatic logic [31:0] crc32_d8(input logic [7:0] d, input logic [31:0] c);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C1_1DB7;
    end
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        frame_done_q, frame_done_d;
  logic [31:0] fcs_hold_q, fcs_hold_d;
  logic [31:0] fcs_out_q, fcs_out_d;

  logic        load;
  logic        accept;
  logic [7:0]  cnt_next;
  logic [8:0]  cnt_p1;
  logic        more_pad;
  logic        need_pad;
  logic [31:0] fcs_rev;

  // Bit-reversed complement: low byte is the first FCS byte on the wire,
  // and the whole word is the FCS in conventional CRC-32 notation.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_fcs_rev
      assign fcs_rev[gi] = ~crc_q[31-gi];
    end
  endgenerate

  assign load     = !m_valid_q || m_ready;
  assign s_ready  = load && ((state_q == ST_IDLE) || (state_q == ST_DATA));
  assign accept   = s_valid && s_ready;
  assign cnt_next = (byte_cnt_q == 8'hFF) ? 8'hFF : byte_cnt_q + 8'd1;
  assign cnt_p1   = {1'b0, byte_cnt_q} + 9'd1;
  assign more_pad = cnt_p1 < MIN_LEN_W;
  assign need_pad = (PAD_EN != 0) && more_pad;

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    byte_cnt_d   = byte_cnt_q;
    fcs_idx_d    = fcs_idx_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;
    fcs_hold_d   = fcs_hold_q;
    fcs_out_d    = fcs_out_q;

    if (load) begin
      case (state_q)
        ST_IDLE, ST_DATA: begin
          if (accept) begin
            m_data_d   = s_data;
            m_valid_d  = 1'b1;
            m_last_d   = 1'b0;
            crc_d      = crc32_d8(s_data, crc_q);
            byte_cnt_d = cnt_next;
            if (s_last) state_d = need_pad ? ST_PAD : ST_FCS;
            else        state_d = ST_DATA;
          end else begin
            m_valid_d = 1'b0;
          end
        end
        ST_PAD: begin
          m_data_d   = 8'h00;
          m_valid_d  = 1'b1;
          m_last_d   = 1'b0;
          crc_d      = crc32_d8(8'h00, crc_q);
          byte_cnt_d = cnt_next;
          if (!more_pad) state_d = ST_FCS;
        end
        default: begin
          // Load with m_last set means the final FCS byte is being taken.
          if (m_valid_q && m_last_q) begin
            frame_done_d = 1'b1;
            fcs_out_d    = fcs_hold_q;
            m_valid_d    = 1'b0;
            m_last_d     = 1'b0;
            crc_d        = CRC_INIT;
            byte_cnt_d   = 8'd0;
            fcs_idx_d    = 2'd0;
            state_d      = ST_IDLE;
          end else begin
            if (fcs_idx_q == 2'd0) fcs_hold_d = fcs_rev;
            m_data_d  = fcs_rev[7:0];
            m_valid_d = 1'b1;
            m_last_d  = (fcs_idx_q == 2'd3);
            crc_d     = {crc_q[23:0], 8'h00};
            fcs_idx_d = fcs_idx_q + 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      crc_q        <= CRC_INIT;
      byte_cnt_q   <= 8'd0;
      fcs_idx_q    <= 2'd0;
      m_data_q     <= 8'h00;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      fcs_hold_q   <= 32'h0;
      fcs_out_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      byte_cnt_q   <= byte_cnt_d;
      fcs_idx_q    <= fcs_idx_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      fcs_hold_q   <= fcs_hold_d;
      fcs_out_q    <= fcs_out_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;
  assign fcs_out    = fcs_out_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_fcs_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eth_tx_fcs_ctrl: directed bench, one unpadded and one padded instance.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_eth_tx_fcs_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sd  = 8'h00;
  logic        sl  = 1'b0;
  logic [1:0]  sv  = 2'b00;
  logic [1:0]  mr  = 2'b11;
  logic [1:0]  rnd = 2'b00;
  logic [1:0]  sr, mv, ml, fdn;
  logic [7:0]  md [2];
  logic [31:0] fo [2];

  int checks = 0;
  int errors = 0;

  logic [8:0]  q0[$], q1[$], expq[$];
  logic [31:0] fo0q[$], fo1q[$];
  int          fdc [2];
  logic        stall_prev [2];
  logic [9:0]  stall_val [2];

  always #5 clk = ~clk;

  eth_tx_fcs_ctrl #(.PAD_EN(0), .MIN_LEN(60)) dut0 (
    .clk(clk), .rst(rst), .s_data(sd), .s_valid(sv[0]), .s_last(sl), .s_ready(sr[0]),
    .m_data(md[0]), .m_valid(mv[0]), .m_last(ml[0]), .m_ready(mr[0]),
    .frame_done(fdn[0]), .fcs_out(fo[0])
  );

  eth_tx_fcs_ctrl #(.PAD_EN(1), .MIN_LEN(60)) dut1 (
    .clk(clk), .rst(rst), .s_data(sd), .s_valid(sv[1]), .s_last(sl), .s_ready(sr[1]),
    .m_data(md[1]), .m_valid(mv[1]), .m_last(ml[1]), .m_ready(mr[1]),
    .frame_done(fdn[1]), .fcs_out(fo[1])
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reflected CRC-32 reference, returns the FCS in conventional notation.
  function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) mr[i] = rnd[i] ? 1'($urandom_range(1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (mv[0] && mr[0]) q0.push_back({ml[0], md[0]});
    if (mv[1] && mr[1]) q1.push_back({ml[1], md[1]});
    if (fdn[0]) begin fdc[0]++; fo0q.push_back(fo[0]); end
    if (fdn[1]) begin fdc[1]++; fo1q.push_back(fo[1]); end
    for (int i = 0; i < 2; i++) begin
      if (!rst && stall_prev[i]) chk("stall_stable", {mv[i], ml[i], md[i]}, stall_val[i]);
      stall_prev[i] = !rst && mv[i] && !mr[i];
      stall_val[i]  = {mv[i], ml[i], md[i]};
    end
  end

  task automatic send(input int sel, input logic [7:0] b[$], input int gap, input bit last);
    int  n;
    bit  acc;
    for (int i = 0; i < b.size(); i++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        sv[sel] = 1'b0;
        @(posedge clk); #1;
      end
      sd = b[i];
      sl = last && (i == b.size() - 1);
      sv[sel] = 1'b1;
      n = 0; acc = 1'b0;
      while (!acc && n < 500) begin
        @(negedge clk); acc = sr[sel];
        @(posedge clk); #1;
        n++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    sv[sel] = 1'b0;
    sl = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int target);
    int n;
    n = 0;
    while (fdc[sel] < target && n < 3000) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
    chk("frame_done_count", fdc[sel], target);
  endtask

  task automatic add_exp(input int sel, input logic [7:0] b[$], output logic [31:0] c);
    logic [7:0] f[$];
    f = b;
    if (sel == 1) while (f.size() < 60) f.push_back(8'h00);
    c = crc_ref(f);
    foreach (f[i]) expq.push_back({1'b0, f[i]});
    expq.push_back({1'b0, c[7:0]});
    expq.push_back({1'b0, c[15:8]});
    expq.push_back({1'b0, c[23:16]});
    expq.push_back({1'b1, c[31:24]});
  endtask

  task automatic check_out(input int sel, input string tag);
    logic [8:0] got[$];
    if (sel == 0) got = q0; else got = q1;
    chk({tag, "_beats"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++) chk(tag, got[i], expq[i]);
    expq.delete();
    q0.delete();
    q1.delete();
  endtask

  initial begin
    logic [7:0]  b[$], b2[$];
    logic [31:0] c, c2;
    int          base, lasts;
    fdc[0] = 0; fdc[1] = 0;
    stall_prev[0] = 1'b0; stall_prev[1] = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", mv[0], 0);
    chk("rst_m_data", md[0], 0);
    chk("rst_m_last", ml[1], 0);
    chk("rst_frame_done", fdn[1], 0);
    chk("rst_fcs_out", fo[0], 0);
    chk("rst_s_ready", sr[1], 1);
    @(posedge clk); #1;

    // "123456789" without padding
    b = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send(0, b, 0, 1'b1);
    wait_done(0, 1);
    chk("check_fcs_out", (fo0q.size() > 0) ? fo0q[$] : 32'h0, 32'hCBF4_3926);
    if (q0.size() == 13) begin
      chk("check_b0", q0[9], {1'b0, 8'h26});
      chk("check_b1", q0[10], {1'b0, 8'h39});
      chk("check_b2", q0[11], {1'b0, 8'hF4});
      chk("check_b3", q0[12], {1'b1, 8'hCB});
    end
    add_exp(0, b, c);
    check_out(0, "check_seq");

    // One-byte frame padded to 60
    b = {8'h00};
    send(1, b, 0, 1'b1);
    wait_done(1, 1);
    add_exp(1, b, c);
    chk("pad_fcs_out", (fo1q.size() > 0) ? fo1q[$] : 32'h0, c);
    check_out(1, "pad_seq");

    // 64-byte frame, no padding needed
    b.delete();
    for (int i = 0; i < 64; i++) b.push_back(8'(i * 3 + 1));
    send(1, b, 0, 1'b1);
    wait_done(1, 2);
    add_exp(1, b, c);
    chk("len64_fcs_out", (fo1q.size() > 0) ? fo1q[$] : 32'h0, c);
    check_out(1, "len64_seq");

    // 100-byte frame with random backpressure and input gaps
    b.delete();
    for (int i = 0; i < 100; i++) b.push_back(8'($urandom_range(255)));
    rnd[1] = 1'b1;
    send(1, b, 30, 1'b1);
    wait_done(1, 3);
    rnd[1] = 1'b0;
    add_exp(1, b, c);
    chk("rand_fcs_out", (fo1q.size() > 0) ? fo1q[$] : 32'h0, c);
    check_out(1, "rand_seq");

    // Back-to-back frames
    base = fdc[0];
    b.delete(); b2.delete();
    for (int i = 0; i < 20; i++) b.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 7; i++) b2.push_back(8'(8'h55 ^ i));
    send(0, b, 0, 1'b1);
    send(0, b2, 0, 1'b1);
    wait_done(0, base + 2);
    add_exp(0, b, c);
    add_exp(0, b2, c2);
    chk("b2b_fcs_a", (fo0q.size() >= 2) ? fo0q[fo0q.size() - 2] : 32'h0, c);
    chk("b2b_fcs_b", (fo0q.size() >= 1) ? fo0q[$] : 32'h0, c2);
    check_out(0, "b2b_seq");

    // Reset in the middle of a frame
    base = fdc[0];
    b = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    send(0, b, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", mv[0], 0);
    chk("midrst_fcs_out", fo[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    lasts = 0;
    foreach (q0[i]) if (q0[i][8]) lasts++;
    chk("midrst_no_last", lasts, 0);
    chk("midrst_no_done", fdc[0], base);
    q0.delete();
    b = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send(0, b, 0, 1'b1);
    wait_done(0, base + 1);
    chk("midrst_fcs_clean", (fo0q.size() > 0) ? fo0q[$] : 32'h0, 32'hCBF4_3926);
    add_exp(0, b, c);
    check_out(0, "midrst_seq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
